// File: rtl/regfile_mp_pkg.sv
// Package: default parameters and address-validity helper for regfile_mp.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package regfile_mp_pkg;

`include "regfile_defs.vh"

  localparam int DEF_N        = `REGFILE_DEF_N;
  localparam int DEF_M        = `REGFILE_DEF_M;
  localparam int DEF_O        = `REGFILE_DEF_O;
  localparam int DEF_RD_PORTS = `REGFILE_DEF_RD_PORTS;
  localparam int MAX_RD_PORTS = `REGFILE_MAX_RD_PORTS;
  localparam int DEF_ZERO_REG = `REGFILE_DEF_ZERO_REG;

  // An address is usable when it names an existing register and is not the
  // hardwired zero register. Used for writes, reservations and reads alike.
  function automatic logic addr_ok(input int a, input int o, input bit zr);
    return (a < o) && !(zr && (a == 0));
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Interface: write ports, read ports, debug read and scoreboard of regfile_mp.
// Latency: n/a (wires only).
// Backpressure: none; every request is accepted in the cycle it is presented.
// master = requester (drives enables/addresses/data), slave = register file.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int M        = DEF_M,
  parameter int O        = DEF_O,
  parameter int RD_PORTS = DEF_RD_PORTS
);
  logic                  we0;
  logic [M-1:0]          waddr0;
  logic [N-1:0]          wdata0;
  logic                  we1;
  logic [M-1:0]          waddr1;
  logic [N-1:0]          wdata1;
  logic [RD_PORTS*M-1:0] raddr;
  logic [RD_PORTS*N-1:0] rdata;
  logic [M-1:0]          inr;
  logic [N-1:0]          outvalue;
  logic                  rsv_en;
  logic [M-1:0]          rsv_addr;
  logic [O-1:0]          pend;
  logic                  wr_conflict;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, inr, rsv_en, rsv_addr,
    input  rdata, outvalue, pend, wr_conflict
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, inr, rsv_en, rsv_addr,
    output rdata, outvalue, pend, wr_conflict
  );
endinterface

// File: rtl/regfile_defs.vh
// Shared defaults for the multi-port register file family.
// Width, address, depth and read-port constants, plus the zero-register default.
// No logic here; included by the package only.
`ifndef REGFILE_DEFS_VH
`define REGFILE_DEFS_VH

`define REGFILE_DEF_N         16
`define REGFILE_DEF_M         4
`define REGFILE_DEF_O         16
`define REGFILE_DEF_RD_PORTS  3
`define REGFILE_MAX_RD_PORTS  8
`define REGFILE_DEF_ZERO_REG  1

`endif

// File: rtl/regfile_rdport.sv
// One read port: range check, zero-register masking, optional write bypass.
// Latency: combinational (0 cycles).
// Backpressure: none.
// Ports: rf (stored array), addr, live write ports (wv/waddr/wdata 0 and 1), data.
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int M        = DEF_M,
  parameter int O        = DEF_O,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter bit BYPASS   = 1'b0
) (
  input  logic [O-1:0][N-1:0] rf,
  input  logic [M-1:0]        addr,
  input  logic                wv0,
  input  logic [M-1:0]        waddr0,
  input  logic [N-1:0]        wdata0,
  input  logic                wv1,
  input  logic [M-1:0]        waddr1,
  input  logic [N-1:0]        wdata1,
  output logic [N-1:0]        data
);
  // wv0/wv1 are already qualified by range and zero-register rules, so a
  // bypass hit can only ever occur on a valid address. Port 1 wins, matching
  // which value the array will hold after the edge.
  always_comb begin
    data = '0;
    if (addr_ok(int'(addr), O, ZERO_REG != 0)) begin
      if (BYPASS && wv1 && (waddr1 == addr)) begin
        data = wdata1;
      end else if (BYPASS && wv0 && (waddr0 == addr)) begin
        data = wdata0;
      end else begin
        data = rf[addr];
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: 2 write ports, RD_PORTS read ports, debug read, scoreboard.
// Latency: writes/pend/wr_conflict update at the next posedge; reads are combinational.
// Backpressure: none; all requests accepted every cycle.
// Ports: clk, rst (sync, active-high), bus (regfile_mp_if.slave).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data onto rdata
// (outvalue is never bypassed).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int M        = DEF_M,
  parameter int O        = DEF_O,          // O <= 2**M
  parameter int RD_PORTS = DEF_RD_PORTS,   // 1..MAX_RD_PORTS
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [O-1:0][N-1:0] rf;
  logic [O-1:0]        pend_q;
  logic [O-1:0]        pend_nxt;
  logic                conflict_q;
  logic                wv0;
  logic                wv1;
  logic                rv;

  // Requests that touch a real register; everything else is silently dropped.
  assign wv0 = bus.we0    && addr_ok(int'(bus.waddr0),   O, ZERO_REG != 0);
  assign wv1 = bus.we1    && addr_ok(int'(bus.waddr1),   O, ZERO_REG != 0);
  assign rv  = bus.rsv_en && addr_ok(int'(bus.rsv_addr), O, ZERO_REG != 0);

  // Commits clear pend, then a reservation sets it: a same-cycle reserve marks
  // a newer producer than the write retiring now, so it must win.
  always_comb begin
    pend_nxt = pend_q;
    for (int i = 0; i < O; i++) begin
      if (wv0 && (int'(bus.waddr0) == i))   pend_nxt[i] = 1'b0;
      if (wv1 && (int'(bus.waddr1) == i))   pend_nxt[i] = 1'b0;
      if (rv  && (int'(bus.rsv_addr) == i)) pend_nxt[i] = 1'b1;
    end
  end

  // Port 1 is written last so it overrides port 0 on an address clash.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf         <= '0;
      pend_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (wv0) rf[bus.waddr0] <= bus.wdata0;
      if (wv1) rf[bus.waddr1] <= bus.wdata1;
      pend_q     <= pend_nxt;
      conflict_q <= wv0 && wv1 && (bus.waddr0 == bus.waddr1);
    end
  end

  assign bus.pend        = pend_q;
  assign bus.wr_conflict = conflict_q;

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    regfile_rdport #(
      .N(N), .M(M), .O(O), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .rf     (rf),
      .addr   (bus.raddr[k*M +: M]),
      .wv0    (wv0),
      .waddr0 (bus.waddr0),
      .wdata0 (bus.wdata0),
      .wv1    (wv1),
      .waddr1 (bus.waddr1),
      .wdata1 (bus.wdata1),
      .data   (bus.rdata[k*N +: N])
    );
  end

  // Debug port always shows stored contents only.
  regfile_rdport #(
    .N(N), .M(M), .O(O), .ZERO_REG(ZERO_REG), .BYPASS(1'b0)
  ) u_dbg (
    .rf     (rf),
    .addr   (bus.inr),
    .wv0    (wv0),
    .waddr0 (bus.waddr0),
    .wdata0 (bus.wdata0),
    .wv1    (wv1),
    .waddr1 (bus.waddr1),
    .wdata1 (bus.wdata1),
    .data   (bus.outvalue)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed scenarios plus randomized traffic against a
// behavioural model (array of registers, array of pend bits, conflict flag).
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int N  = 16;
  localparam int M  = 4;
  localparam int O  = 12;
  localparam int RP = 3;
  localparam int ZR = 1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.N(N), .M(M), .O(O), .RD_PORTS(RP)) bus ();

  regfile_mp #(.N(N), .M(M), .O(O), .RD_PORTS(RP), .ZERO_REG(ZR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [N-1:0] mrf   [O];
  bit           mpend [O];
  bit           mconf;
  int           total;
  int           bad;

  function automatic bit okw(input int a);
    return (a < O) && !(ZR != 0 && a == 0);
  endfunction

  function automatic logic [N-1:0] exp_rd(input int a);
    if (!okw(a)) return '0;
    if (BYP) begin
      if (bus.we1 && okw(int'(bus.waddr1)) && int'(bus.waddr1) == a) return bus.wdata1;
      if (bus.we0 && okw(int'(bus.waddr0)) && int'(bus.waddr0) == a) return bus.wdata0;
    end
    return mrf[a];
  endfunction

  function automatic logic [N-1:0] exp_dbg(input int a);
    return (a < O) ? mrf[a] : '0;
  endfunction

  function automatic logic [O-1:0] exp_pend();
    logic [O-1:0] e;
    for (int i = 0; i < O; i++) e[i] = mpend[i];
    return e;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void compare_all();
    for (int k = 0; k < RP; k++)
      chk($sformatf("rdata%0d", k), 32'(bus.rdata[k*N +: N]), 32'(exp_rd(int'(bus.raddr[k*M +: M]))));
    chk("outvalue", 32'(bus.outvalue), 32'(exp_dbg(int'(bus.inr))));
    chk("pend", 32'(bus.pend), 32'(exp_pend()));
    chk("wr_conflict", 32'(bus.wr_conflict), 32'(mconf));
  endfunction

  task automatic model_update();
    int a0;
    int a1;
    int ra;
    bit v0;
    bit v1;
    a0 = int'(bus.waddr0);
    a1 = int'(bus.waddr1);
    ra = int'(bus.rsv_addr);
    if (rst) begin
      for (int i = 0; i < O; i++) begin
        mrf[i]   = '0;
        mpend[i] = 1'b0;
      end
      mconf = 1'b0;
    end else begin
      v0 = bus.we0 && okw(a0);
      v1 = bus.we1 && okw(a1);
      mconf = v0 && v1 && (a0 == a1);
      if (v0) begin mrf[a0] = bus.wdata0; mpend[a0] = 1'b0; end
      if (v1) begin mrf[a1] = bus.wdata1; mpend[a1] = 1'b0; end
      if (bus.rsv_en && okw(ra)) mpend[ra] = 1'b1;
    end
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.raddr = '0; bus.inr = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
  endtask

  // Called at negedge with inputs applied: check, then advance one edge.
  task automatic cyc(input bit cmp);
    #1;
    if (cmp) compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mconf = 1'b0;
    rst   = 1'b1;
    idle();
    @(negedge clk);
    cyc(1'b0);
    rst = 1'b0;

    // Preload r3 and reserve it in the same cycle.
    bus.we0 = 1'b1; bus.waddr0 = 4'd3; bus.wdata0 = 16'h1234;
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd3;
    cyc(1'b1);
    idle(); bus.inr = 4'd3;
    #1;
    chk("preload_r3", 32'(bus.outvalue), 32'h1234);
    chk("preload_pend3", 32'(bus.pend[3]), 32'd1);

    // Reset clears everything.
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    for (int a = 0; a < 16; a += RP) begin
      idle();
      for (int k = 0; k < RP; k++) bus.raddr[k*M +: M] = M'((a + k) % 16);
      bus.inr = M'(a);
      #1;
      for (int k = 0; k < RP; k++) chk("reset_rdata", 32'(bus.rdata[k*N +: N]), 32'd0);
      chk("reset_pend", 32'(bus.pend), 32'd0);
      chk("reset_conflict", 32'(bus.wr_conflict), 32'd0);
      cyc(1'b1);
    end

    // Dual write to r5: port 1 wins, one-cycle conflict pulse.
    bus.we0 = 1'b1; bus.waddr0 = 4'd5; bus.wdata0 = 16'hAAAA;
    bus.we1 = 1'b1; bus.waddr1 = 4'd5; bus.wdata1 = 16'h5555;
    cyc(1'b1);
    idle(); bus.inr = 4'd5;
    #1;
    chk("dual_r5", 32'(bus.outvalue), 32'h5555);
    chk("dual_conflict_hi", 32'(bus.wr_conflict), 32'd1);
    cyc(1'b1);
    #1;
    chk("dual_conflict_lo", 32'(bus.wr_conflict), 32'd0);

    // Zero register ignores writes and reservations, never conflicts.
    bus.we0 = 1'b1; bus.waddr0 = 4'd0; bus.wdata0 = 16'hFFFF;
    bus.we1 = 1'b1; bus.waddr1 = 4'd0; bus.wdata1 = 16'hFFFF;
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd0;
    cyc(1'b1);
    idle();
    #1;
    chk("zero_rdata", 32'(bus.rdata[0 +: N]), 32'd0);
    chk("zero_pend0", 32'(bus.pend[0]), 32'd0);
    chk("zero_conflict", 32'(bus.wr_conflict), 32'd0);

    // Scoreboard on r7.
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd7;
    cyc(1'b1);
    idle();
    #1;
    chk("sb_reserve", 32'(bus.pend[7]), 32'd1);
    bus.we0 = 1'b1; bus.waddr0 = 4'd7; bus.wdata0 = 16'h0077;
    cyc(1'b1);
    idle();
    #1;
    chk("sb_retire", 32'(bus.pend[7]), 32'd0);
    bus.we1 = 1'b1; bus.waddr1 = 4'd7; bus.wdata1 = 16'h0777;
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd7;
    cyc(1'b1);
    idle(); bus.inr = 4'd7;
    #1;
    chk("sb_same_cycle", 32'(bus.pend[7]), 32'd1);
    chk("sb_r7_data", 32'(bus.outvalue), 32'h0777);

    // Bypass behaviour on r2.
    bus.we0 = 1'b1; bus.waddr0 = 4'd2; bus.wdata0 = 16'h0011;
    cyc(1'b1);
    idle();
    bus.we0 = 1'b1; bus.waddr0 = 4'd2; bus.wdata0 = 16'h00C3;
    bus.raddr[0 +: M] = 4'd2; bus.inr = 4'd2;
    #1;
    chk("byp_rdata", 32'(bus.rdata[0 +: N]), BYP ? 32'h00C3 : 32'h0011);
    chk("byp_outvalue", 32'(bus.outvalue), 32'h0011);
    cyc(1'b1);
    idle(); bus.raddr[0 +: M] = 4'd2;
    #1;
    chk("byp_after", 32'(bus.rdata[0 +: N]), 32'h00C3);

    // Out-of-range write, reservation and reads.
    bus.we0 = 1'b1; bus.waddr0 = 4'd13; bus.wdata0 = 16'h0BAD;
    bus.we1 = 1'b1; bus.waddr1 = 4'd12; bus.wdata1 = 16'h0BAD;
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd13;
    cyc(1'b1);
    idle();
    bus.raddr[0 +: M] = 4'd13; bus.raddr[M +: M] = 4'd12; bus.raddr[2*M +: M] = 4'd5;
    bus.inr = 4'd13;
    #1;
    chk("range_rd13", 32'(bus.rdata[0 +: N]), 32'd0);
    chk("range_rd12", 32'(bus.rdata[N +: N]), 32'd0);
    chk("range_r5_kept", 32'(bus.rdata[2*N +: N]), 32'h5555);
    chk("range_dbg13", 32'(bus.outvalue), 32'd0);
    chk("range_pend", 32'(bus.pend), 32'h0080);
    chk("range_conflict", 32'(bus.wr_conflict), 32'd0);
    cyc(1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.we0 = 1'($urandom_range(0, 1));
      bus.we1 = 1'($urandom_range(0, 1));
      bus.waddr0 = M'($urandom_range(0, 15));
      bus.waddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr0 : M'($urandom_range(0, 15));
      bus.wdata0 = N'($urandom);
      bus.wdata1 = N'($urandom);
      bus.rsv_en = ($urandom_range(0, 2) == 0);
      bus.rsv_addr = ($urandom_range(0, 3) == 0) ? bus.waddr0 : M'($urandom_range(0, 15));
      for (int k = 0; k < RP; k++)
        bus.raddr[k*M +: M] = ($urandom_range(0, 2) == 0) ? bus.waddr1 : M'($urandom_range(0, 15));
      bus.inr = M'($urandom_range(0, 15));
      cyc(1'b1);
    end
    rst = 1'b0;
    idle();
    cyc(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, two-read CPU register file.
- Provides 2 write ports and RD_PORTS read ports, plus a debug read port.
- Adds optional hardwired-zero register 0, synchronous clear, and a per-register pending (scoreboard) bit for the upcoming pipelined datapath.
- Also flags dual writes to the same address.

Parameters:
- N, 16, data width in bits
- M, 4, address width in bits
- O, 16, number of registers (O <= 2**M)
- RD_PORTS, 3, number of read ports (1..8)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and reservations

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- we0  in  1  write enable, port 0
- waddr0  in  M  write address, port 0
- wdata0  in  N  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- waddr1  in  M  write address, port 1
- wdata1  in  N  write data, port 1
- raddr  in  RD_PORTS*M  packed read addresses; port k at [k*M +: M]
- rdata  out  RD_PORTS*N  packed read data; port k at [k*N +: N]
- inr  in  M  debug read address
- outvalue  out  N  debug read data; never bypassed
- rsv_en  in  1  mark a register pending
- rsv_addr  in  M  register to mark pending
- pend  out  O  pending bit per register
- wr_conflict  out  1  registered pulse on a same-address dual write

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous, active-high.
- While rst=1 at a posedge: all O registers are cleared to 0, pend is cleared to 0, and wr_conflict is cleared to 0. Writes and reservations in that cycle are discarded.
- rdata and outvalue are combinational, so they show 0 in the cycle after reset.
- Reset asserted mid-stream wins over every other event in that cycle.
- Write commit: at posedge, rf[waddrX] <= wdataX when weX=1.
- Dual write, same address: port 1 data is stored and port 0 is dropped. On the next posedge wr_conflict is 1 for exactly one cycle, then returns to 0.
- Dual write, different addresses: both are stored.
- Ignored writes:
  - any write with address >= O is ignored and has no side effects;
  - when ZERO_REG=1, writes to address 0 are ignored and never raise wr_conflict.
- Reads: asynchronous. rdata port k = rf[raddr k].
  - Address >= O reads 0.
  - When ZERO_REG=1, address 0 reads 0.
- Scoreboard:
  - rsv_en=1 sets pend[rsv_addr] at posedge.
  - A committed write to a register clears its pend bit at posedge.
  - Reservation and write to the same register in the same cycle: the reservation wins and pend stays 1 (new producer).
  - Reserving an already pending register leaves it set.
  - Reservations to address >= O, or to 0 when ZERO_REG=1, are ignored.
- Latency: write-to-read is 1 cycle without bypass and 0 cycles with bypass; pend updates 1 cycle after the request.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: each rdata port forwards same-cycle write data when raddr matches an active, valid waddr. Port 1 data takes priority over port 0. The zero-register and out-of-range rules still apply.
- Undefined: rdata shows only stored contents; a new value is visible from the cycle after the write.
- outvalue is never bypassed in either build.

Decomposition:
- Shared include regfile_defs.vh holds:
  - default width, address and depth constants;
  - the maximum RD_PORTS constant;
  - the ZERO_REG default.
- Natural sub-module: regfile_rdport, instantiated RD_PORTS times via generate. It handles range check, zero-register masking and optional bypass muxing for one read port.
- The storage array, write arbitration, scoreboard and conflict flag stay in regfile_mp.

Test Plan:
- Reset: preload r3=16'h1234 with pend[3]=1, then assert rst for one cycle -> rdata shows 0 at every address, pend=0, wr_conflict=0.
- Dual-write conflict: we0=we1=1, waddr0=waddr1=5, wdata0=16'hAAAA, wdata1=16'h5555 -> r5=16'h5555; wr_conflict=1 for exactly one cycle after the edge, then 0.
- Zero register (ZERO_REG=1): write 16'hFFFF to r0 and rsv_en with rsv_addr=0 -> r0 reads 0, pend[0]=0, wr_conflict=0.
- Scoreboard: reserve r7, then on a later cycle write r7 -> pend[7]=1 after the reserve, 0 after the write. Reserve and write r7 in the same cycle -> pend[7] stays 1.
- Bypass (REGFILE_BYPASS_EN defined): write r2=16'h00C3 while raddr port 0 = 2 -> rdata port 0 = 16'h00C3 in the same cycle, while outvalue with inr=2 shows the old value. Without the macro, rdata port 0 shows the old value until the next cycle.
- Depth/range (O=12, M=4): write address 13 with 16'h0BAD -> no register changes; reading address 13 returns 0.
